// File: rtl/trace_pkg.sv
// Shared types and constants for the trace decode path: instruction classes,
// the decoded record layout and the classifier.
package trace_pkg;

    localparam int TR_XLEN = 32;

    localparam logic [31:0] OP_NOP   = 32'h0000_0013;
    localparam logic [31:0] OP_MARK  = 32'h0000_4033;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        MARK    = 3'd1,
        JALR    = 3'd2,
        OTHER   = 3'd3,
        ILLEGAL = 3'd4
    } op_class_e;

    typedef struct packed {
        op_class_e            cls;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [TR_XLEN-1:0]   imm;
        logic [31:0]          op;
        logic [TR_XLEN-1:0]   pc;
    } trace_rec_t;

    // Ordered tests: the exact-match markers must win over the generic rules.
    function automatic op_class_e classify(input logic [31:0] op);
        if (op == OP_NOP)
            return NOP;
        else if (op == OP_MARK)
            return MARK;
        else if (op[6:0] == OPC_JALR && op[14:12] == 3'b000)
            return JALR;
        else if (op[1:0] != 2'b11 || op == 32'h0)
            return ILLEGAL;
        else
            return OTHER;
    endfunction

endpackage

// File: rtl/rv_trace_decode_if.sv
// Record stream handshakes: retired instructions in, decoded records out.
interface rv_trace_decode_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_op;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_class;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [XLEN-1:0] out_imm;
    logic [31:0]     out_op;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_op, in_pc, out_ready,
        input  in_ready, out_valid, out_class, out_rd, out_rs1, out_imm, out_op, out_pc
    );

    modport slave (
        input  in_valid, in_op, in_pc, out_ready,
        output in_ready, out_valid, out_class, out_rd, out_rs1, out_imm, out_op, out_pc
    );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of decoded trace records; the head entry is held in an
// output register so consumers never see a combinational path from the input.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  trace_rec_t  din,
    input  logic        pop,
    output trace_rec_t  dout,
    output logic        empty,
    output logic [AW:0] count
);

    trace_rec_t    mem [DEPTH];
    trace_rec_t    dout_reg, dout_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          do_push, do_pop;

    assign do_push = push && (count_reg != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        dout_next   = dout_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            // Next head comes from storage unless the queue is (or is becoming)
            // empty, in which case the incoming record goes straight to the head.
            if (do_pop && count_reg > (AW+1)'(1))
                dout_next = mem[rd_ptr_reg + 1'b1];
            else if (do_push && (count_reg == '0 || (do_pop && count_reg == (AW+1)'(1))))
                dout_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

    assign dout  = dout_reg;
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/rv_trace_decode.sv
// Classifies retired instruction words, extracts rd/rs1/imm, queues the records
// for the trace printer and keeps retired/illegal instruction counters.
module rv_trace_decode
    import trace_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int XLEN   = TR_XLEN,
    parameter int ICNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    rv_trace_decode_if.slave   bus,
    output logic [31:0]        retired_cnt,
    output logic [ICNT_W-1:0]  illegal_cnt
);

    localparam int AW = $clog2(DEPTH);

    op_class_e         in_cls;
    trace_rec_t        in_rec;
    trace_rec_t        out_rec;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              push, pop;
    logic [31:0]       retired_cnt_reg;
    logic [ICNT_W-1:0] illegal_cnt_reg;

    // Illegal words carry no meaningful fields, so they are zeroed for the printer.
    always_comb begin
        in_cls     = classify(bus.in_op);
        in_rec     = '0;
        in_rec.cls = in_cls;
        in_rec.op  = bus.in_op;
        in_rec.pc  = bus.in_pc;
        if (in_cls != ILLEGAL) begin
            in_rec.rd  = bus.in_op[11:7];
            in_rec.rs1 = bus.in_op[19:15];
            in_rec.imm = {{(TR_XLEN-12){bus.in_op[31]}}, bus.in_op[31:20]};
        end
    end

    assign bus.in_ready  = (fifo_count < (AW+1)'(DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (in_rec),
        .pop   (pop),
        .dout  (out_rec),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_class = out_rec.cls;
    assign bus.out_rd    = out_rec.rd;
    assign bus.out_rs1   = out_rec.rs1;
    assign bus.out_imm   = out_rec.imm;
    assign bus.out_op    = out_rec.op;
    assign bus.out_pc    = out_rec.pc;

    // A push in a flush cycle still completed its handshake, so it is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_reg <= '0;
            illegal_cnt_reg <= '0;
        end else if (push) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
            if (in_cls == ILLEGAL && illegal_cnt_reg != '1)
                illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: doc/rv_trace_decode.md
Name: rv_trace_decode

Overview:
- Upstream feeder for the simulation-side RISC-V disassembly/trace printer.
- Accepts retired 32-bit instruction words with their PC over a valid/ready handshake, classifies each one and extracts its register and immediate fields.
- Buffers the decoded records in a small FIFO and presents them to the printer stage over a second valid/ready handshake.
- Keeps running counts of retired and illegal instructions for end-of-test summaries.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- XLEN, 32: width of PC and of the sign-extended immediate.
- ICNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous: clear FIFO contents; counters are kept.
- in_valid  input  1  upstream record valid.
- in_ready  output  1  block can accept a record this cycle.
- in_op  input  32  instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  decoded record available.
- out_ready  input  1  downstream accepts the record.
- out_class  output  3  op_class_e value.
- out_rd  output  5  op[11:7].
- out_rs1  output  5  op[19:15].
- out_imm  output  XLEN  op[31:20] sign-extended.
- out_op  output  32  original word.
- out_pc  output  XLEN  original PC.
- retired_cnt  output  32  accepted-record count; wraps modulo 2^32.
- illegal_cnt  output  ICNT_W  count of ILLEGAL records; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; in_ready=1, out_valid=0.
  - All out_* data fields = 0; retired_cnt=0, illegal_cnt=0.
  - Reset asserted mid-transfer discards all entries; no record is emitted after release.
- Input transfer: occurs when in_valid && in_ready on a clk edge.
  - in_ready = (count < DEPTH); it does not depend on out_ready, so a full FIFO stalls even if a pop happens in the same cycle.
- Classification (combinational, on in_op), first match wins:
  - NOP = 0x00000013.
  - MARK = 0x00004033.
  - JALR when op[6:0]=1100111 and op[14:12]=000.
  - ILLEGAL when op[1:0]!=2'b11 or op==0.
  - OTHER for everything else.
- Field extraction:
  - Rd, rs1 and imm are taken from the bit positions above for every class.
  - For ILLEGAL records, rd, rs1 and imm are forced to 0.
- Latency: a record accepted at edge N is visible on out_* at N+1 (registered FIFO output).
  - There is no combinational in-to-out path.
- Output transfer: occurs when out_valid && out_ready.
  - out_* fields hold stable while out_valid=1 && out_ready=0.
  - When out_valid=0, out_* hold the last popped values.
- Simultaneous push and pop when not full: count is unchanged and order is preserved (strict FIFO).
- Pointers: log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Counters:
  - retired_cnt increments on every input transfer.
  - illegal_cnt increments on input transfers classified ILLEGAL and holds at its maximum.
  - Both counters are unaffected by flush.
- Flush:
  - Empties the FIFO next edge (count=0, out_valid=0).
  - A push in the flush cycle is dropped but still counted, because the input handshake completed.
  - A pop in the flush cycle completes normally downstream.
  - in_ready stays per the pre-flush count during the flush cycle.

Decomposition:
- Package trace_pkg holds:
  - op_class_e: 3-bit enum {NOP, MARK, JALR, OTHER, ILLEGAL}.
  - Constants OP_NOP=32'h00000013, OP_MARK=32'h00004033, OPC_JALR=7'b1100111.
  - Packed struct trace_rec_t {class, rd, rs1, imm, op, pc}.
- Sub-module trace_fifo: generic synchronous FIFO of trace_rec_t with DEPTH, push/pop/flush, full/empty/count, and a registered read port.
- rv_trace_decode holds the classifier, the field extraction and the counters.

Test Plan:
- Reset release, then push op=0x00000013 pc=0x100 with out_ready=1 -> next cycle out_valid=1, class=NOP, rd=0, rs1=0, imm=0x13>>... i.e. imm=0, pc=0x100; retired_cnt=1.
- Push op=0xFFF28067 (jalr x0,-1(x5)) -> class=JALR, rd=0, rs1=5, imm=0xFFFFFFFF.
- Push op=0x00004033, then op=0x00000000, then op=0x12345670 -> classes MARK, ILLEGAL, ILLEGAL; illegal_cnt=2; illegal records show rd=rs1=imm=0.
- Hold out_ready=0 and offer 6 pushes with DEPTH=4:
  - in_ready drops after 4 accepts.
  - out_* stays at the first record.
  - Releasing out_ready drains pc values in order; retired_cnt=4 until the stalled pushes are accepted.
- With 3 entries queued, assert flush together with in_valid -> next cycle out_valid=0, count=0; retired_cnt still increments by 1.
- Assert rst_n=0 mid-stream for a partial cycle (asynchronous) -> out_valid and counters 0 immediately; force illegal_cnt to the all-ones state (ICNT_W=2, 4 illegals) -> it saturates at 3.
